// File: rtl/vip_axi4_wr_tracker_if.sv
// AXI4 write-channel handshake signals observed by the write tracker.
// The tracker only listens, so its modport is input-only.
interface vip_axi4_wr_tracker_if;
  logic       awvalid;
  logic       awready;
  logic [7:0] awlen;
  logic       wvalid;
  logic       wready;
  logic       wlast;
  logic       bvalid;
  logic       bready;

  modport master (
    output awvalid, awready, awlen, wvalid, wready, wlast, bvalid, bready
  );

  modport slave (
    input awvalid, awready, awlen, wvalid, wready, wlast, bvalid, bready
  );
endinterface

// File: rtl/vip_axi4_wr_tracker.sv
// Passive AXI4 write-protocol tracker: queues AW burst lengths, checks W beat counts
// against them, counts bursts awaiting B and raises sticky protocol-error flags.
module vip_axi4_wr_tracker #(
  parameter int unsigned AW_DEPTH_P  = 8,
  parameter int unsigned CNT_WIDTH_P = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  vip_axi4_wr_tracker_if.slave          bus,
  output logic [$clog2(AW_DEPTH_P):0]   aw_pending,
  output logic [CNT_WIDTH_P-1:0]        b_pending,
  output logic                          idle,
  output logic                          err_aw_overflow,
  output logic                          err_w_no_aw,
  output logic                          err_wlast_early,
  output logic                          err_wlast_missing,
  output logic                          err_b_unexpected,
  output logic                          err_any
);

  localparam int unsigned PW = $clog2(AW_DEPTH_P);
  localparam logic [PW:0] DepthCnt = AW_DEPTH_P[PW:0];
  localparam logic [CNT_WIDTH_P-1:0] BMax = '1;

  logic [7:0]             mem_q [AW_DEPTH_P];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]            count_q, count_d;
  logic [7:0]             beat_q, beat_d;
  logic [CNT_WIDTH_P-1:0] bpend_q, bpend_d;
  logic [4:0]             err_q, err_d;
  logic                   idle_q, idle_d;
  logic                   err_any_q;

  logic       aw_hs, w_hs, b_hs;
  logic       fifo_empty, fifo_full;
  logic       have_head, w_ok, w_done, at_last;
  logic       push, pop, bypass, overflow;
  logic       b_unexp, b_dec;
  logic [7:0] head;

  always_comb begin
    aw_hs      = bus.awvalid & bus.awready;
    w_hs       = bus.wvalid & bus.wready;
    b_hs       = bus.bvalid & bus.bready;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DepthCnt);

    // An empty FIFO lets a same-cycle AW act as the head (bypass).
    have_head  = !fifo_empty || aw_hs;
    head       = fifo_empty ? bus.awlen : mem_q[rd_ptr_q];
    w_ok       = w_hs && have_head;
    at_last    = (beat_q >= head);
    w_done     = w_ok && (at_last || bus.wlast);

    bypass     = fifo_empty && w_done;
    pop        = w_done && !fifo_empty;
    push       = aw_hs && !bypass && (!fifo_full || pop);
    overflow   = aw_hs && fifo_full && !pop;

    b_unexp    = b_hs && (bpend_q == '0);
    b_dec      = b_hs && (bpend_q != '0);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    beat_d   = beat_q;
    bpend_d  = bpend_q;
    err_d    = err_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    if (w_done)    beat_d = '0;
    else if (w_ok) beat_d = beat_q + 8'd1;

    // Completion and B in the same cycle cancel out; saturate rather than wrap.
    if (w_done && !b_dec && (bpend_q != BMax)) bpend_d = bpend_q + 1'b1;
    else if (b_dec && !w_done)                 bpend_d = bpend_q - 1'b1;

    // err bits: {aw_overflow, w_no_aw, wlast_early, wlast_missing, b_unexpected}
    if (overflow)                             err_d[4] = 1'b1;
    if (w_hs && !have_head)                   err_d[3] = 1'b1;
    if (w_ok && bus.wlast && !at_last)        err_d[2] = 1'b1;
    if (w_ok && !bus.wlast && at_last)        err_d[1] = 1'b1;
    if (b_unexp)                              err_d[0] = 1'b1;

    idle_d = (count_d == '0) && (bpend_d == '0) && (beat_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      beat_q    <= '0;
      bpend_q   <= '0;
      err_q     <= '0;
      idle_q    <= 1'b1;
      err_any_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      beat_q    <= beat_d;
      bpend_q   <= bpend_d;
      err_q     <= err_d;
      idle_q    <= idle_d;
      err_any_q <= |err_d;
    end
  end

  // Storage needs no reset: entries are only read when count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.awlen;
  end

  assign aw_pending        = count_q;
  assign b_pending         = bpend_q;
  assign idle              = idle_q;
  assign err_aw_overflow   = err_q[4];
  assign err_w_no_aw       = err_q[3];
  assign err_wlast_early   = err_q[2];
  assign err_wlast_missing = err_q[1];
  assign err_b_unexpected  = err_q[0];
  assign err_any           = err_any_q;

endmodule

// File: tb/tb_vip_axi4_wr_tracker.sv
// Self-checking bench for vip_axi4_wr_tracker: directed vector table, hand-written
// corner sequences, then randomized traffic against a queue-based reference model.
module tb_vip_axi4_wr_tracker;

  localparam int Depth = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vip_axi4_wr_tracker_if bus ();

  logic [3:0]  aw_pending;
  logic [15:0] b_pending;
  logic        idle, err_aw_overflow, err_w_no_aw, err_wlast_early;
  logic        err_wlast_missing, err_b_unexpected, err_any;

  vip_axi4_wr_tracker #(.AW_DEPTH_P(Depth), .CNT_WIDTH_P(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus.slave),
    .aw_pending        (aw_pending),
    .b_pending         (b_pending),
    .idle              (idle),
    .err_aw_overflow   (err_aw_overflow),
    .err_w_no_aw       (err_w_no_aw),
    .err_wlast_early   (err_wlast_early),
    .err_wlast_missing (err_wlast_missing),
    .err_b_unexpected  (err_b_unexpected),
    .err_any           (err_any)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // err vector order: {overflow, w_no_aw, early, missing, b_unexpected}
  typedef struct {
    bit         aw;
    logic [7:0] awlen;
    bit         w;
    bit         wl;
    bit         b;
    int         awp;
    int         bp;
    bit         idl;
    logic [4:0] err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit aw, int len, bit w, bit wl, bit b,
                              int awp, int bp, bit idl, logic [4:0] err);
    vec_t v;
    v.aw = aw; v.awlen = 8'(len); v.w = w; v.wl = wl; v.b = b;
    v.awp = awp; v.bp = bp; v.idl = idl; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int awp, input int bp, input bit idl,
                           input logic [4:0] err);
    logic [4:0] got;
    got = {err_aw_overflow, err_w_no_aw, err_wlast_early, err_wlast_missing,
           err_b_unexpected};
    chk({tag, ".aw_pending"}, 32'(aw_pending), 32'(awp));
    chk({tag, ".b_pending"},  32'(b_pending),  32'(bp));
    chk({tag, ".idle"},       32'(idle),       32'(idl));
    chk({tag, ".err"},        32'(got),        32'(err));
    chk({tag, ".err_any"},    32'(err_any),    32'(|err));
  endtask

  // Non-handshake cycles still toggle valid or ready to show the AND matters.
  function automatic logic [1:0] no_hs();
    int r = $urandom_range(0, 2);
    return (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b10;
  endfunction

  task automatic drive(input bit aw, input logic [7:0] len, input bit w, input bit wl,
                       input bit b);
    {bus.awvalid, bus.awready} = aw ? 2'b11 : no_hs();
    {bus.wvalid, bus.wready}   = w  ? 2'b11 : no_hs();
    {bus.bvalid, bus.bready}   = b  ? 2'b11 : no_hs();
    bus.awlen = aw ? len : 8'($urandom);
    bus.wlast = w ? wl : 1'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    #1 rst = 1'b0;
  endtask

  // Reference model: a queue of outstanding burst lengths plus plain counters.
  int         q[$];
  int         m_beat, m_bp;
  logic [4:0] m_err;

  function automatic void model_clear();
    q.delete();
    m_beat = 0; m_bp = 0; m_err = '0;
  endfunction

  function automatic void model_step(bit aw, int len, bit w, bit wl, bit b);
    int  size0 = q.size();
    bit  done  = 0;
    int  head  = (size0 > 0) ? q[0] : (aw ? len : -1);
    if (w) begin
      if (head < 0) m_err[3] = 1'b1;
      else if (wl || m_beat == head) begin
        done = 1;
        if (wl && m_beat < head) m_err[2] = 1'b1;
        if (!wl)                 m_err[1] = 1'b1;
        m_beat = 0;
      end else m_beat++;
    end
    if (aw) begin
      if (size0 == Depth && !done) m_err[4] = 1'b1;
      else q.push_back(len);
    end
    if (done) void'(q.pop_front());
    if (b) begin
      if (m_bp == 0) m_err[0] = 1'b1;
      else m_bp--;
    end
    if (done && m_bp < 65535) m_bp++;
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0);
    #12 rst = 1'b0;
    #1;
    check_out("reset", 0, 0, 1, 5'h00);

    //         aw len w wl b   awp bp idle err
    tbl.push_back(mk(1, 3, 0, 0, 0, 1, 0, 0, 5'h00));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 5'h00));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 5'h00));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 5'h00));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 5'h00));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 5'h00));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 1, 0, 5'h00)); // AW/W bypass
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 5'h00));
    tbl.push_back(mk(1, 3, 0, 0, 0, 1, 0, 0, 5'h00));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 5'h00));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 5'h04)); // early wlast
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 2, 0, 5'h04));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, 5'h04));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 2, 0, 5'h04)); // completion + B cancel
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 5'h04));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 5'h04));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 5'h05)); // B with nothing pending
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 5'h0D)); // W with no AW
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 5'h0D));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 5'h0F)); // missing wlast
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 5'h0F));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 5'h0F));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 5'h0F));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 5'h0F));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 5'h0F)); // B with 1 pending + completion
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 5'h0F));

    foreach (tbl[i]) begin
      drive(tbl[i].aw, tbl[i].awlen, tbl[i].w, tbl[i].wl, tbl[i].b);
      step();
      check_out($sformatf("vec%0d", i), tbl[i].awp, tbl[i].bp, tbl[i].idl, tbl[i].err);
    end

    // Asynchronous reset in the middle of a long burst.
    drive(1, 7, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0); step();
    drive(0, 0, 1, 0, 0); step();
    check_out("pre_rst", 1, 0, 0, 5'h0F);
    drive(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 check_out("async_rst", 0, 0, 1, 5'h00);
    #2 rst = 1'b0;
    step();
    drive(1, 0, 1, 1, 0); step();
    check_out("post_rst", 0, 1, 0, 5'h00);
    drive(0, 0, 0, 0, 1); step();
    check_out("post_rst_b", 0, 0, 1, 5'h00);

    // Fill the FIFO, push while popping when full, then overflow.
    do_reset();
    for (int i = 0; i < Depth; i++) begin
      drive(1, 0, 0, 0, 0); step();
    end
    check_out("full", Depth, 0, 0, 5'h00);
    drive(1, 0, 1, 1, 0); step();
    check_out("full_push_pop", Depth, 1, 0, 5'h00);
    drive(1, 0, 0, 0, 0); step();
    check_out("overflow", Depth, 1, 0, 5'h10);

    do_reset();
    drive(0, 0, 1, 1, 0); step();
    check_out("w_no_aw", 0, 0, 1, 5'h08);

    // Randomized traffic against the reference model, with periodic resets.
    do_reset();
    model_clear();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit aw, w, wl, b;
      int len, head;
      if (cyc % 500 == 499) begin
        do_reset();
        model_clear();
        check_out($sformatf("rnd_rst%0d", cyc), 0, 0, 1, 5'h00);
      end
      aw   = ($urandom_range(0, 2) == 0);
      len  = $urandom_range(0, 3);
      w    = ($urandom_range(0, 1) == 0);
      head = (q.size() > 0) ? q[0] : (aw ? len : -1);
      wl   = (head >= 0 && m_beat == head) ? ($urandom_range(0, 9) != 0)
                                           : ($urandom_range(0, 19) == 0);
      b    = (m_bp > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      drive(aw, 8'(len), w, wl, b);
      model_step(aw, len, w, wl, b);
      step();
      check_out($sformatf("rnd%0d", cyc), q.size(), m_bp,
                (q.size() == 0 && m_bp == 0 && m_beat == 0), m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
